traffic_phase_ctrl: RTL and testbench

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_phase_ctrl.sv | 176 +++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Two-axis traffic light phase controller: eight-stage straight/left/yellow cycle
// with night flash, all-red freeze and manual stepping, driven from a 1 s tick.
module traffic_phase_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int TIME_W     = 10,
    parameter int T_STRAIGHT = 30,
    parameter int T_LEFT     = 15,
    parameter int T_YELLOW   = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [1:0]        mode,
    input  logic              step,
    output logic [2:0]        state,
    output logic [3:0]        ns_lamp,
    output logic [3:0]        ew_lamp,
    output logic [TIME_W-1:0] ns_time,
    output logic [TIME_W-1:0] ew_time,
    output logic              tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    localparam logic [1:0] M_NORMAL = 2'b00;
    localparam logic [1:0] M_NIGHT  = 2'b01;
    localparam logic [1:0] M_ALLRED = 2'b10;

    localparam logic [2:0] S0 = 3'd0;

    localparam logic [TIME_W-1:0] D_STR  = TIME_W'(T_STRAIGHT);
    localparam logic [TIME_W-1:0] D_LEFT = TIME_W'(T_LEFT);
    localparam logic [TIME_W-1:0] D_YEL  = TIME_W'(T_YELLOW);
    localparam logic [TIME_W-1:0] ONE    = TIME_W'(1);
    localparam logic [TIME_W-1:0] ZERO   = '0;

    // Lamp encoding {left, green, yellow, red}
    localparam logic [3:0] L_GREEN = 4'b0100;
    localparam logic [3:0] L_YEL   = 4'b0010;
    localparam logic [3:0] L_LEFT  = 4'b1001;
    localparam logic [3:0] L_RED   = 4'b0001;
    localparam logic [3:0] L_OFF   = 4'b0000;

    logic [DIV_W-1:0]  div;
    logic [TIME_W-1:0] cnt;
    logic              flash;
    logic [1:0]        mode_r;

    logic [2:0]        nxt_state;
    logic [2:0]        adv_state;
    logic [TIME_W-1:0] nxt_cnt;
    logic              nxt_flash;
    logic [3:0]        act_lamp;
    logic [TIME_W-1:0] red_time;

    // Stage index within a half: 0 straight, 1 yellow, 2 left, 3 left-yellow
    function automatic logic [TIME_W-1:0] stage_dur(input logic [1:0] ph);
        case (ph)
            2'd0:    stage_dur = D_STR;
            2'd2:    stage_dur = D_LEFT;
            default: stage_dur = D_YEL;
        endcase
    endfunction

    // Time left in this half after the current stage ends
    function automatic logic [TIME_W-1:0] rest_dur(input logic [1:0] ph);
        case (ph)
            2'd0:    rest_dur = D_YEL + D_LEFT + D_YEL;
            2'd1:    rest_dur = D_LEFT + D_YEL;
            2'd2:    rest_dur = D_YEL;
            default: rest_dur = ZERO;
        endcase
    endfunction

    function automatic logic [3:0] stage_lamp(input logic [1:0] ph);
        case (ph)
            2'd0:    stage_lamp = L_GREEN;
            2'd2:    stage_lamp = L_LEFT;
            default: stage_lamp = L_YEL;
        endcase
    endfunction

    assign tick = (div == DIV_MAX) && !sys_rst;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div <= '0;
        end else if (div == DIV_MAX) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_flash = flash;
        adv_state = state + 3'd1;
        // Leaving night mode always restarts the cycle from the beginning
        if (mode_r == M_NIGHT && mode != M_NIGHT) begin
            nxt_state = S0;
            nxt_cnt   = D_STR;
            nxt_flash = 1'b0;
        end else begin
            case (mode)
                M_NORMAL: begin
                    if (tick) begin
                        if (cnt <= ONE) begin
                            nxt_state = adv_state;
                            nxt_cnt   = stage_dur(adv_state[1:0]);
                        end else begin
                            nxt_cnt = cnt - ONE;
                        end
                    end
                end
                M_NIGHT: begin
                    nxt_state = S0;
                    nxt_cnt   = D_STR;
                    if (tick) begin
                        nxt_flash = ~flash;
                    end
                end
                M_ALLRED: begin
                    nxt_state = state;
                end
                default: begin
                    if (step) begin
                        nxt_state = adv_state;
                        nxt_cnt   = stage_dur(adv_state[1:0]);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= S0;
            cnt    <= D_STR;
            flash  <= 1'b0;
            mode_r <= M_NORMAL;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            flash  <= nxt_flash;
            mode_r <= mode;
        end
    end

    always_comb begin
        act_lamp = stage_lamp(state[1:0]);
        red_time = cnt + rest_dur(state[1:0]);
        if (!state[2]) begin
            ns_lamp = act_lamp;
            ew_lamp = L_RED;
            ns_time = cnt;
            ew_time = red_time;
        end else begin
            ns_lamp = L_RED;
            ew_lamp = act_lamp;
            ns_time = red_time;
            ew_time = cnt;
        end
        if (mode_r == M_NIGHT) begin
            ns_lamp = flash ? L_YEL : L_OFF;
            ew_lamp = flash ? L_YEL : L_OFF;
            ns_time = ZERO;
            ew_time = ZERO;
        end else if (mode_r == M_ALLRED) begin
            ns_lamp = L_RED;
            ew_lamp = L_RED;
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a 4-cycle tick and short stage times.
module tb_traffic_phase_ctrl;

    localparam int TIME_W = 10;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic              step = 1'b0;
    logic [2:0]        state;
    logic [3:0]        ns_lamp;
    logic [3:0]        ew_lamp;
    logic [TIME_W-1:0] ns_time;
    logic [TIME_W-1:0] ew_time;
    logic              tick;

    int total = 0;
    int bad   = 0;

    traffic_phase_ctrl #(
        .TICK_DIV(4), .TIME_W(TIME_W), .T_STRAIGHT(5), .T_LEFT(3), .T_YELLOW(2)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .mode(mode), .step(step),
        .state(state), .ns_lamp(ns_lamp), .ew_lamp(ew_lamp),
        .ns_time(ns_time), .ew_time(ew_time), .tick(tick)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        mode    = 2'b00;
        step    = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    // Park on a negedge where tick is high, bounded.
    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 10) begin
            total++; bad++;
            $display("FAIL tick_timeout got=%b exp=1", tick);
        end
    endtask

    task automatic tick_edge();
        wait_tick();
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
        total++; if (ns_lamp !== 4'b0100) begin bad++; $display("FAIL rst_ns_lamp got=%b exp=0100", ns_lamp); end
        total++; if (ew_lamp !== 4'b0001) begin bad++; $display("FAIL rst_ew_lamp got=%b exp=0001", ew_lamp); end
        total++; if (ns_time !== 10'd5) begin bad++; $display("FAIL rst_ns_time got=%0d exp=5", ns_time); end
        total++; if (ew_time !== 10'd12) begin bad++; $display("FAIL rst_ew_time got=%0d exp=12", ew_time); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b exp=0", tick); end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sys_clk);
            if (i == 2) begin
                total++; if (tick !== 1'b0) begin bad++; $display("FAIL tick_early got=%b exp=0", tick); end
            end
            if (i == 3) begin
                total++; if (tick !== 1'b1) begin bad++; $display("FAIL tick_first got=%b exp=1", tick); end
            end
        end
        total++; if (state !== 3'd1) begin bad++; $display("FAIL s1_state got=%0d exp=1", state); end
        total++; if (ns_lamp !== 4'b0010) begin bad++; $display("FAIL s1_ns_lamp got=%b exp=0010", ns_lamp); end
        total++; if (ns_time !== 10'd2) begin bad++; $display("FAIL s1_ns_time got=%0d exp=2", ns_time); end
        total++; if (ew_time !== 10'd7) begin bad++; $display("FAIL s1_ew_time got=%0d exp=7", ew_time); end
    endtask

    task automatic test_full_cycle();
        logic [2:0] seq [24] = '{0,0,0,0,0,1,1,2,2,2,3,3,4,4,4,4,4,5,5,6,6,6,7,7};
        logic [3:0] ns_tab [8] = '{4'b0100, 4'b0010, 4'b1001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        logic [3:0] ew_tab [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0010, 4'b1001, 4'b0010};
        do_reset();
        for (int k = 0; k < 24; k++) begin
            wait_tick();
            total++; if (state !== seq[k]) begin bad++; $display("FAIL cyc_state k=%0d got=%0d exp=%0d", k, state, seq[k]); end
            total++; if (ns_lamp !== ns_tab[seq[k]] || ew_lamp !== ew_tab[seq[k]]) begin
                bad++; $display("FAIL cyc_lamps k=%0d got=%b/%b exp=%b/%b", k, ns_lamp, ew_lamp, ns_tab[seq[k]], ew_tab[seq[k]]);
            end
            if (k < 12) begin
                total++; if (ew_time !== 10'(12 - k)) begin bad++; $display("FAIL cyc_ew_time k=%0d got=%0d exp=%0d", k, ew_time, 12 - k); end
            end else begin
                total++; if (ns_time !== 10'(24 - k)) begin bad++; $display("FAIL cyc_ns_time k=%0d got=%0d exp=%0d", k, ns_time, 24 - k); end
            end
            @(negedge sys_clk);
        end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL cyc_wrap got=%0d exp=0", state); end
        total++; if (ns_time !== 10'd5) begin bad++; $display("FAIL cyc_wrap_time got=%0d exp=5", ns_time); end
    endtask

    task automatic test_night();
        logic [3:0] exp_l;
        do_reset();
        tick_edge();
        tick_edge();
        mode = 2'b01;
        @(negedge sys_clk);
        total++; if (ns_lamp !== 4'b0000 || ew_lamp !== 4'b0000) begin bad++; $display("FAIL night_entry got=%b/%b exp=0000/0000", ns_lamp, ew_lamp); end
        total++; if (ns_time !== 10'd0 || ew_time !== 10'd0) begin bad++; $display("FAIL night_times got=%0d/%0d exp=0/0", ns_time, ew_time); end
        for (int i = 1; i <= 6; i++) begin
            tick_edge();
            exp_l = (i % 2 == 1) ? 4'b0010 : 4'b0000;
            total++; if (ns_lamp !== exp_l || ew_lamp !== exp_l) begin
                bad++; $display("FAIL night_flash i=%0d got=%b/%b exp=%b", i, ns_lamp, ew_lamp, exp_l);
            end
        end
        mode = 2'b00;
        @(negedge sys_clk);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL night_exit_state got=%0d exp=0", state); end
        total++; if (ns_time !== 10'd5 || ew_time !== 10'd12) begin bad++; $display("FAIL night_exit_time got=%0d/%0d exp=5/12", ns_time, ew_time); end
        total++; if (ns_lamp !== 4'b0100) begin bad++; $display("FAIL night_exit_lamp got=%b exp=0100", ns_lamp); end
    endtask

    task automatic test_allred();
        do_reset();
        for (int i = 0; i < 8; i++) tick_edge();
        total++; if (state !== 3'd2 || ns_time !== 10'd2 || ew_time !== 10'd4) begin
            bad++; $display("FAIL ar_pre got=%0d/%0d/%0d exp=2/2/4", state, ns_time, ew_time);
        end
        mode = 2'b10;
        @(negedge sys_clk);
        total++; if (ns_lamp !== 4'b0001 || ew_lamp !== 4'b0001) begin bad++; $display("FAIL ar_lamps got=%b/%b exp=0001/0001", ns_lamp, ew_lamp); end
        for (int i = 0; i < 10; i++) tick_edge();
        total++; if (state !== 3'd2 || ns_time !== 10'd2 || ew_time !== 10'd4) begin
            bad++; $display("FAIL ar_frozen got=%0d/%0d/%0d exp=2/2/4", state, ns_time, ew_time);
        end
        total++; if (ns_lamp !== 4'b0001 || ew_lamp !== 4'b0001) begin bad++; $display("FAIL ar_hold got=%b/%b exp=0001/0001", ns_lamp, ew_lamp); end
        mode = 2'b00;
        @(negedge sys_clk);
        total++; if (ns_lamp !== 4'b1001) begin bad++; $display("FAIL ar_resume_lamp got=%b exp=1001", ns_lamp); end
        tick_edge();
        total++; if (state !== 3'd2 || ns_time !== 10'd1) begin bad++; $display("FAIL ar_resume1 got=%0d/%0d exp=2/1", state, ns_time); end
        tick_edge();
        total++; if (state !== 3'd3 || ns_time !== 10'd2) begin bad++; $display("FAIL ar_resume2 got=%0d/%0d exp=3/2", state, ns_time); end
    endtask

    task automatic test_manual();
        do_reset();
        mode = 2'b11;
        @(negedge sys_clk);
        step = 1'b1;
        @(negedge sys_clk);
        step = 1'b0;
        total++; if (state !== 3'd1 || ns_time !== 10'd2) begin bad++; $display("FAIL man_s1 got=%0d/%0d exp=1/2", state, ns_time); end
        tick_edge();
        tick_edge();
        total++; if (state !== 3'd1 || ns_time !== 10'd2) begin bad++; $display("FAIL man_no_tick got=%0d/%0d exp=1/2", state, ns_time); end
        step = 1'b1;
        @(negedge sys_clk);
        step = 1'b0;
        total++; if (state !== 3'd2 || ns_time !== 10'd3 || ew_time !== 10'd5) begin
            bad++; $display("FAIL man_s2 got=%0d/%0d/%0d exp=2/3/5", state, ns_time, ew_time);
        end
        wait_tick();
        step = 1'b1;
        @(negedge sys_clk);
        step = 1'b0;
        total++; if (state !== 3'd3 || ns_time !== 10'd2) begin bad++; $display("FAIL man_coincide got=%0d/%0d exp=3/2", state, ns_time); end
        mode = 2'b00;
        step = 1'b1;
        @(negedge sys_clk);
        step = 1'b0;
        total++; if (state !== 3'd3 || ns_time !== 10'd2) begin bad++; $display("FAIL step_normal got=%0d/%0d exp=3/2", state, ns_time); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 17; i++) tick_edge();
        total++; if (state !== 3'd5) begin bad++; $display("FAIL ar5_state got=%0d exp=5", state); end
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL arst_state got=%0d exp=0", state); end
        total++; if (ns_lamp !== 4'b0100 || ew_lamp !== 4'b0001) begin bad++; $display("FAIL arst_lamps got=%b/%b exp=0100/0001", ns_lamp, ew_lamp); end
        total++; if (ns_time !== 10'd5 || ew_time !== 10'd12) begin bad++; $display("FAIL arst_times got=%0d/%0d exp=5/12", ns_time, ew_time); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL arst_tick got=%b exp=0", tick); end
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_night();
        test_allred();
        test_manual();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
